man_scheduler: RTL and testbench
================================

# man_scheduler

Job scheduler and reorder buffer for a bank of Mandelbrot iteration engines. It walks pixel coordinates in raster order and dispatches one pixel per cycle to a free engine, picked round-robin. It collects each engine's iteration count out of order and emits the counts in raster order on the 32-bit video AXI-Stream, marking frame start on `tuser` and line end on `tlast`. It sits between the pixel engines and the colour-map/video DMA stage.

## Interface
- `N_ENGINES`, 4: number of attached iteration engines (1..8).
- `ROB_DEPTH`, 4: reorder-buffer entries; power of two, ≥ `N_ENGINES`.
- `X_SIZE`, 640: pixels per line.
- `Y_SIZE`, 480: lines per frame.
- `ITER_W`, 8: iteration-count width.

Ports:
- `out_stream_aclk` in 1: single clock for the whole block.
- `periph_reset` in 1: reset, synchronous, active-high.
- `enable` in 1: level; run frames while high.
- `eng_start` out N_ENGINES: one-hot start pulse, one cycle.
- `eng_x` out 10: pixel x for the started engine; valid only with `eng_start`.
- `eng_y` out 9: pixel y for the started engine; valid only with `eng_start`.
- `eng_done` in N_ENGINES: per-engine one-cycle completion pulse.
- `eng_iter` in N_ENGINES*ITER_W: per-engine result, slice i = bits [i*ITER_W +: ITER_W]; valid with `eng_done[i]`.
- `out_stream_tdata` out 32: {zeros, iter}.
- `out_stream_tkeep` out 4: constant 4'hF.
- `out_stream_tvalid` out 1: stream handshake valid.
- `out_stream_tready` in 1: stream handshake ready.
- `out_stream_tlast` out 1: last pixel of a line.
- `out_stream_tuser` out 1: first pixel of a frame.
- `busy` out 1: high in ISSUE or DRAIN.

## Operation
- Reset clears the following:
  - FSM goes to IDLE.
  - Issue and output x/y counters are cleared.
  - Issue and read sequence pointers are cleared.
  - Round-robin pointer is cleared.
  - All engine-busy flags and ROB valid bits are cleared.
- Output values under reset: `eng_start`=0, `out_stream_tvalid`=0, `tuser`=0, `tlast`=0, `busy`=0.
- FSM states:
  - IDLE: `enable`=1 → ISSUE; the issue counters restart at (0,0).
  - ISSUE: issue one pixel per cycle when an engine is free AND outstanding < `ROB_DEPTH`. Outstanding = issue_seq − read_seq. After pixel (X_SIZE−1, Y_SIZE−1) is issued → DRAIN.
  - DRAIN: no issue. When the last pixel of the frame is accepted on the stream:
    - `enable`=1 → ISSUE (new frame).
    - `enable`=0 → IDLE.
  - `enable` falling mid-frame does not stop the frame; the frame always completes.
- Arbitration:
  - Round-robin over free engines, starting at `rr_ptr`.
  - After a grant to engine g, `rr_ptr` = (g+1) mod N_ENGINES.
- Per-engine tag register holds `issue_seq` mod `ROB_DEPTH`, captured at start.
- Engine busy flag:
  - Set on start.
  - Cleared on `eng_done`. The engine becomes grantable the following cycle, not the same cycle.
- `eng_done[i]` while engine i is not busy is ignored.
- On `eng_done[i]`, `rob[tag[i]]` ← `eng_iter[i]` and its valid bit is set.
  - Multiple dones in one cycle write distinct entries, and all are captured.
- Output side:
  - `tvalid` = `rob[read_seq mod ROB_DEPTH].valid`; data comes from that entry.
  - On `tvalid & tready`: clear the entry's valid bit, increment `read_seq`, and advance the output x/y counters.
  - `tuser` = output counters at (0,0).
  - `tlast` = output x == X_SIZE−1.
- Counter wrap:
  - x wraps at X_SIZE−1, and y increments on that wrap.
  - y wraps at Y_SIZE−1 to 0.
  - Sequence pointers are `log2(ROB_DEPTH)+1` bits and wrap freely.

## Timing
- From `enable` rising in IDLE:
  - ISSUE is entered the next cycle.
  - The first `eng_start` occurs in the cycle after that, with (0,0).
- `eng_start`, `eng_x` and `eng_y` are registered outputs.
- `eng_done` → `tvalid`: one cycle (ROB write, then registered valid).
- `tvalid` and `tdata`, `tuser`, `tlast` are stable until accepted; `tvalid` never drops without a handshake.
- With N engines, each of latency L, and `tready`=1, sustained throughput is min(1, N/(L+1)) pixels/cycle.
- A full ROB stalls issue. Issue resumes the cycle after the handshake that frees an entry.
- Simultaneous handshake and done on different entries: both take effect.

## Test plan
- Setup for all scenarios: X_SIZE=4, Y_SIZE=2, N_ENGINES=2, ROB_DEPTH=4, engine model with programmable latency.
- Single engine, latency 3, `tready`=1.
  - Starts (0,0),(1,0)…(3,1), one every 4 cycles.
  - 8 beats; `tuser` on beat 0; `tlast` on beats 3 and 7; then IDLE with `enable`=0.
- Two engines returning out of order (engine1 latency 1, engine0 latency 5).
  - Stream order is still pixel 0,1,2…; data = pixel index.
  - No beat is lost or duplicated.
- `tready`=0 for 20 cycles.
  - Exactly 4 jobs are issued, then issue stalls.
  - `tvalid` holds beat 0 steady.
  - After `tready`=1, issue resumes one cycle after the first handshake.
- `enable` dropped after 3 pixels issued: all 8 pixels are still emitted, `busy` falls after the final `tlast`, and the block ends in IDLE.
- `enable` held high: the second frame's first beat has `tuser`=1 and coordinates restart at (0,0).
- `periph_reset` asserted mid-frame with 2 jobs outstanding.
  - Next cycle: `tvalid`=0, `eng_start`=0, `busy`=0.
  - A late `eng_done` is ignored.
  - The frame restarts at (0,0) on `enable`.

Source files
------------

// File: rtl/man_scheduler.sv
// Mandelbrot job scheduler: raster-order round-robin dispatch to an engine bank, reorder buffer, in-order AXI-Stream out.
// Latency: start two cycles after enable, done->tvalid one cycle. Backpressure: low tready or a full ROB stalls issue.
module man_scheduler #(
  parameter int N_ENGINES = 4,
  parameter int ROB_DEPTH = 4,
  parameter int X_SIZE    = 640,
  parameter int Y_SIZE    = 480,
  parameter int ITER_W    = 8
) (
  input  logic                        out_stream_aclk,
  input  logic                        periph_reset,
  input  logic                        enable,
  output logic [N_ENGINES-1:0]        eng_start,
  output logic [9:0]                  eng_x,
  output logic [8:0]                  eng_y,
  input  logic [N_ENGINES-1:0]        eng_done,
  input  logic [N_ENGINES*ITER_W-1:0] eng_iter,
  output logic [31:0]                 out_stream_tdata,
  output logic [3:0]                  out_stream_tkeep,
  output logic                        out_stream_tvalid,
  input  logic                        out_stream_tready,
  output logic                        out_stream_tlast,
  output logic                        out_stream_tuser,
  output logic                        busy
);
  localparam int ENG_W = (N_ENGINES > 1) ? $clog2(N_ENGINES) : 1;
  localparam int IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int SEQ_W = $clog2(ROB_DEPTH) + 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  logic [1:0]           r_state;
  logic [9:0]           r_ix;
  logic [8:0]           r_iy;
  logic [9:0]           r_ox;
  logic [8:0]           r_oy;
  logic [SEQ_W-1:0]     r_issue_seq;
  logic [SEQ_W-1:0]     r_read_seq;
  logic [ENG_W-1:0]     r_rr_ptr;
  logic [N_ENGINES-1:0] r_eng_busy;
  logic [IDX_W-1:0]     r_tag [N_ENGINES];
  logic [ITER_W-1:0]    r_rob_dat [ROB_DEPTH];
  logic [ROB_DEPTH-1:0] r_rob_vld;
  logic [N_ENGINES-1:0] r_start;
  logic [9:0]           r_ex;
  logic [8:0]           r_ey;

  logic [IDX_W-1:0]     w_rd_idx;
  logic [IDX_W-1:0]     w_wr_idx;
  logic [SEQ_W-1:0]     w_outstanding;
  logic                 w_tvalid;
  logic                 w_hs;
  logic                 w_rob_room;
  logic                 w_gnt_vld;
  logic [ENG_W-1:0]     w_gnt_idx;
  logic                 w_issue;
  logic                 w_ix_last;
  logic                 w_iy_last;
  logic                 w_ox_last;
  logic                 w_oy_last;
  logic                 w_frame_out;

  assign w_rd_idx      = IDX_W'(r_read_seq & SEQ_W'(ROB_DEPTH - 1));
  assign w_wr_idx      = IDX_W'(r_issue_seq & SEQ_W'(ROB_DEPTH - 1));
  assign w_outstanding = r_issue_seq - r_read_seq;
  assign w_tvalid      = r_rob_vld[w_rd_idx];
  assign w_hs          = w_tvalid & out_stream_tready;
  // The entry freed by this cycle's handshake may be reused by this cycle's grant.
  assign w_rob_room    = (w_outstanding != SEQ_W'(ROB_DEPTH)) | w_hs;
  assign w_issue       = (r_state == S_ISSUE) & w_gnt_vld & w_rob_room;
  assign w_ix_last     = (r_ix == 10'(X_SIZE - 1));
  assign w_iy_last     = (r_iy == 9'(Y_SIZE - 1));
  assign w_ox_last     = (r_ox == 10'(X_SIZE - 1));
  assign w_oy_last     = (r_oy == 9'(Y_SIZE - 1));
  assign w_frame_out   = w_hs & w_ox_last & w_oy_last;

  always_comb begin : p_arb
    int               j;
    logic [ENG_W-1:0] jj;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    for (int k = 0; k < N_ENGINES; k++) begin
      j = int'(r_rr_ptr) + k;
      if (j >= N_ENGINES) j = j - N_ENGINES;
      jj = ENG_W'(j);
      if (!w_gnt_vld && !r_eng_busy[jj]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = jj;
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_state <= S_IDLE;
    end else begin
      case (r_state)
        S_IDLE:  if (enable) r_state <= S_ISSUE;
        S_ISSUE: if (w_issue && w_ix_last && w_iy_last) r_state <= S_DRAIN;
        S_DRAIN: if (w_frame_out) r_state <= enable ? S_ISSUE : S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_ix    <= '0;
      r_iy    <= '0;
      r_start <= '0;
      r_ex    <= '0;
      r_ey    <= '0;
    end else begin
      r_start <= w_issue ? (N_ENGINES'(1) << w_gnt_idx) : '0;
      if (w_issue) begin
        r_ex <= r_ix;
        r_ey <= r_iy;
      end
      if (r_state == S_IDLE && enable) begin
        r_ix <= '0;
        r_iy <= '0;
      end else if (w_issue) begin
        if (w_ix_last) begin
          r_ix <= '0;
          r_iy <= w_iy_last ? '0 : r_iy + 1'b1;
        end else begin
          r_ix <= r_ix + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (periph_reset) begin
      r_issue_seq <= '0;
      r_read_seq  <= '0;
      r_rr_ptr    <= '0;
      r_eng_busy  <= '0;
      r_rob_vld   <= '0;
      r_ox        <= '0;
      r_oy        <= '0;
    end else begin
      if (w_issue) begin
        r_issue_seq <= r_issue_seq + 1'b1;
        r_rr_ptr    <= (int'(w_gnt_idx) == N_ENGINES - 1) ? '0 : w_gnt_idx + 1'b1;
      end
      if (w_hs) begin
        r_read_seq          <= r_read_seq + 1'b1;
        r_rob_vld[w_rd_idx] <= 1'b0;
        if (w_ox_last) begin
          r_ox <= '0;
          r_oy <= w_oy_last ? '0 : r_oy + 1'b1;
        end else begin
          r_ox <= r_ox + 1'b1;
        end
      end
      // A done from an idle engine (e.g. one started before a reset) is dropped.
      for (int i = 0; i < N_ENGINES; i++) begin
        if (eng_done[i] && r_eng_busy[i]) begin
          r_rob_vld[r_tag[i]] <= 1'b1;
          r_eng_busy[i]       <= 1'b0;
        end else if (w_issue && w_gnt_idx == ENG_W'(i)) begin
          r_eng_busy[i] <= 1'b1;
        end
      end
    end
  end

  always_ff @(posedge out_stream_aclk) begin
    if (w_issue) r_tag[w_gnt_idx] <= w_wr_idx;
    for (int i = 0; i < N_ENGINES; i++) begin
      if (eng_done[i] && r_eng_busy[i]) r_rob_dat[r_tag[i]] <= eng_iter[i*ITER_W +: ITER_W];
    end
  end

  assign eng_start         = r_start;
  assign eng_x             = r_ex;
  assign eng_y             = r_ey;
  assign out_stream_tdata  = 32'(r_rob_dat[w_rd_idx]);
  assign out_stream_tkeep  = 4'hF;
  assign out_stream_tvalid = w_tvalid;
  assign out_stream_tuser  = w_tvalid & (r_ox == '0) & (r_oy == '0);
  assign out_stream_tlast  = w_tvalid & w_ox_last;
  assign busy              = (r_state != S_IDLE);
endmodule

// File: tb/tb_man_scheduler.sv
// Bench for man_scheduler on a 4x2 frame with two engines of programmable latency.
module tb_man_scheduler;
  localparam int NE = 2;
  localparam int RD = 4;
  localparam int XS = 4;
  localparam int YS = 2;
  localparam int IW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             periph_reset, enable, tready;
  logic [NE-1:0]    eng_start, eng_done;
  logic [9:0]       eng_x;
  logic [8:0]       eng_y;
  logic [NE*IW-1:0] eng_iter;
  logic [31:0]      tdata;
  logic [3:0]       tkeep;
  logic             tvalid, tlast, tuser, busy;

  typedef struct packed {
    logic [31:0] dat;
    logic        user;
    logic        last;
  } beat_t;

  beat_t         sb_q[$];
  int            n_checks = 0;
  int            n_fail   = 0;
  int            cyc      = 0;
  int            n_starts = 0;
  int            n_beats  = 0;
  int            lat [NE];
  int            rem [NE];
  logic [IW-1:0] pix [NE];

  man_scheduler #(
    .N_ENGINES(NE), .ROB_DEPTH(RD), .X_SIZE(XS), .Y_SIZE(YS), .ITER_W(IW)
  ) dut (
    .out_stream_aclk  (clk),
    .periph_reset     (periph_reset),
    .enable           (enable),
    .eng_start        (eng_start),
    .eng_x            (eng_x),
    .eng_y            (eng_y),
    .eng_done         (eng_done),
    .eng_iter         (eng_iter),
    .out_stream_tdata (tdata),
    .out_stream_tkeep (tkeep),
    .out_stream_tvalid(tvalid),
    .out_stream_tready(tready),
    .out_stream_tlast (tlast),
    .out_stream_tuser (tuser),
    .busy             (busy)
  );

  always @(posedge clk) cyc <= cyc + 1;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push_frame();
    for (int p = 0; p < XS * YS; p++) sb_q.push_back({32'(p), p == 0, (p % XS) == XS - 1});
  endtask

  // Latency counts the start cycle: latency L raises done L-1 cycles after start; iter = pixel index.
  task automatic engine_model();
    logic [NE-1:0] d;
    forever begin
      @(negedge clk);
      d = '0;
      for (int i = 0; i < NE; i++) begin
        if (eng_start[i] === 1'b1) begin
          rem[i] = lat[i];
          pix[i] = IW'(int'(eng_y) * XS + int'(eng_x));
        end
        if (rem[i] > 0) begin
          rem[i] = rem[i] - 1;
          if (rem[i] == 0) d[i] = 1'b1;
        end
        eng_iter[i*IW +: IW] = pix[i];
      end
      eng_done = d;
    end
  endtask

  task automatic monitor();
    int    ex_ix = 0;
    int    ex_iy = 0;
    logic  stall_prev = 1'b0;
    beat_t held = '0;
    beat_t got, exp;
    forever begin
      @(negedge clk);
      if (periph_reset) begin
        ex_ix = 0;
        ex_iy = 0;
        stall_prev = 1'b0;
      end else begin
        if (eng_start != '0) begin
          n_starts++;
          n_checks++;
          if (!$onehot(eng_start) || eng_x != ex_ix || eng_y != ex_iy) begin
            n_fail++;
            $display("FAIL issue: start=%b x=%0d y=%0d, required one-hot at x=%0d y=%0d", eng_start, eng_x, eng_y, ex_ix, ex_iy);
          end
          if (ex_ix == XS - 1) begin
            ex_ix = 0;
            ex_iy = (ex_iy == YS - 1) ? 0 : ex_iy + 1;
          end else begin
            ex_ix++;
          end
        end
        got = {tdata, tuser, tlast};
        if (stall_prev) begin
          n_checks++;
          if (tvalid !== 1'b1 || got !== held) begin
            n_fail++;
            $display("FAIL hold: tvalid=%b data=%0d user=%b last=%b, required held beat data=%0d user=%b last=%b", tvalid, got.dat, got.user, got.last, held.dat, held.user, held.last);
          end
        end
        if (tvalid === 1'b1 && tready === 1'b1) begin
          n_beats++;
          n_checks++;
          if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL beat: unexpected beat data=%0d, required no beat", got.dat);
          end else begin
            exp = sb_q.pop_front();
            if (got !== exp) begin
              n_fail++;
              $display("FAIL beat: data=%0d user=%b last=%b, required data=%0d user=%b last=%b", got.dat, got.user, got.last, exp.dat, exp.user, exp.last);
            end
          end
        end
        stall_prev = tvalid && !tready;
        held = got;
      end
    end
  endtask

  task automatic test_reset();
    periph_reset = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    repeat (3) step();
    n_checks++;
    if ({eng_start, tvalid, tuser, tlast, busy} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: start=%b tvalid=%b tuser=%b tlast=%b busy=%b, required all 0", eng_start, tvalid, tuser, tlast, busy);
    end
    n_checks++;
    if (tkeep !== 4'hF) begin
      n_fail++;
      $display("FAIL reset_tkeep: %h, required f", tkeep);
    end
    periph_reset = 1'b0;
    step();
  endtask

  task automatic test_single_engine();
    int last_start [NE] = '{-1, -1};
    int s0 = n_starts;
    lat = '{3, 3};
    push_frame();
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      step();
      for (int e = 0; e < NE; e++) begin
        if (eng_start[e] === 1'b1) begin
          if (last_start[e] >= 0) begin
            n_checks++;
            if (cyc - last_start[e] != 4) begin
              n_fail++;
              $display("FAIL single_period: engine %0d restarted after %0d cycles, required 4", e, cyc - last_start[e]);
            end
          end
          last_start[e] = cyc;
        end
      end
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0 || n_starts - s0 != 8) begin
      n_fail++;
      $display("FAIL single_drain: pending=%0d busy=%b starts=%0d, required 0 0 8", sb_q.size(), busy, n_starts - s0);
    end
  endtask

  task automatic test_out_of_order();
    int b0 = n_beats;
    lat = '{5, 1};
    push_frame();
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      step();
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0 || n_beats - b0 != 8) begin
      n_fail++;
      $display("FAIL ooo_drain: pending=%0d busy=%b beats=%0d, required 0 0 8", sb_q.size(), busy, n_beats - b0);
    end
  endtask

  task automatic test_backpressure();
    int s0 = n_starts;
    lat = '{2, 2};
    push_frame();
    tready = 1'b0;
    enable = 1'b1;
    step();
    enable = 1'b0;
    repeat (20) step();
    n_checks++;
    if (n_starts - s0 != 4) begin
      n_fail++;
      $display("FAIL bp_stall: %0d jobs issued, required 4", n_starts - s0);
    end
    n_checks++;
    if (tvalid !== 1'b1 || tdata !== 32'd0 || tuser !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_beat0: tvalid=%b data=%0d tuser=%b, required 1 0 1", tvalid, tdata, tuser);
    end
    tready = 1'b1;
    step();
    n_checks++;
    if (eng_start === '0) begin
      n_fail++;
      $display("FAIL bp_resume: eng_start=%b one cycle after handshake, required nonzero", eng_start);
    end
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      step();
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0 || n_starts - s0 != 8) begin
      n_fail++;
      $display("FAIL bp_drain: pending=%0d busy=%b starts=%0d, required 0 0 8", sb_q.size(), busy, n_starts - s0);
    end
  endtask

  task automatic test_enable_drop();
    int   s0 = n_starts;
    logic saw = 1'b0;
    lat = '{2, 2};
    push_frame();
    enable = 1'b1;
    for (int c = 0; c < 50 && n_starts - s0 < 3; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 300; c++) begin
      step();
      if (saw) begin
        n_checks++;
        if (busy !== 1'b0) begin
          n_fail++;
          $display("FAIL drop_busy_fall: busy=%b after final tlast, required 0", busy);
        end
        break;
      end
      if (tvalid === 1'b1 && tready === 1'b1 && tlast === 1'b1 && tdata === 32'd7) begin
        n_checks++;
        if (busy !== 1'b1) begin
          n_fail++;
          $display("FAIL drop_busy_hold: busy=%b at final tlast, required 1", busy);
        end
        saw = 1'b1;
      end
    end
    repeat (5) step();
    n_checks++;
    if (!saw || sb_q.size() != 0 || busy !== 1'b0 || n_starts - s0 != 8) begin
      n_fail++;
      $display("FAIL drop_end: last_seen=%b pending=%0d busy=%b starts=%0d, required 1 0 0 8", saw, sb_q.size(), busy, n_starts - s0);
    end
  endtask

  task automatic test_two_frames();
    int s0 = n_starts;
    int b0 = n_beats;
    lat = '{2, 1};
    push_frame();
    push_frame();
    enable = 1'b1;
    for (int c = 0; c < 200 && n_starts - s0 < 9; c++) step();
    enable = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      step();
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0 || n_beats - b0 != 16) begin
      n_fail++;
      $display("FAIL frames_drain: pending=%0d busy=%b beats=%0d, required 0 0 16", sb_q.size(), busy, n_beats - b0);
    end
  endtask

  task automatic test_reset_mid_frame();
    int s0 = n_starts;
    int b0;
    int late_vld = 0;
    lat = '{6, 6};
    enable = 1'b1;
    for (int c = 0; c < 50 && n_starts - s0 < 2; c++) step();
    n_checks++;
    if (n_starts - s0 != 2) begin
      n_fail++;
      $display("FAIL rst_setup: %0d jobs outstanding, required 2", n_starts - s0);
    end
    periph_reset = 1'b1;
    enable = 1'b0;
    step();
    n_checks++;
    if (tvalid !== 1'b0 || eng_start !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid: tvalid=%b start=%b busy=%b, required 0 0 0", tvalid, eng_start, busy);
    end
    periph_reset = 1'b0;
    sb_q.delete();
    repeat (10) begin
      step();
      if (tvalid !== 1'b0) late_vld++;
    end
    n_checks++;
    if (late_vld != 0) begin
      n_fail++;
      $display("FAIL rst_late_done: tvalid seen in %0d cycles, required 0", late_vld);
    end
    lat = '{2, 2};
    b0 = n_beats;
    push_frame();
    enable = 1'b1;
    step();
    enable = 1'b0;
    for (int c = 0; c < 300; c++) begin
      if (sb_q.size() == 0 && busy === 1'b0) break;
      step();
    end
    n_checks++;
    if (sb_q.size() != 0 || busy !== 1'b0 || n_beats - b0 != 8) begin
      n_fail++;
      $display("FAIL rst_restart: pending=%0d busy=%b beats=%0d, required 0 0 8", sb_q.size(), busy, n_beats - b0);
    end
  endtask

  initial begin
    periph_reset = 1'b1;
    enable = 1'b0;
    tready = 1'b1;
    eng_done = '0;
    eng_iter = '0;
    for (int i = 0; i < NE; i++) begin
      rem[i] = 0;
      pix[i] = '0;
      lat[i] = 1;
    end
    fork
      engine_model();
      monitor();
    join_none
    test_reset();
    test_single_engine();
    test_out_of_order();
    test_backpressure();
    test_enable_drop();
    test_two_frames();
    test_reset_mid_frame();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end
endmodule
